// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: load/store op codes, RAM address width,
// FSM state encoding and the access-width decode.
package mem_access_pkg;

  localparam int RAM_ADDR_W  = 17;
  localparam int ALUOP_BUS_W = 8;

  localparam logic [7:0] EXE_ADD = 8'h20;
  localparam logic [7:0] EXE_LB  = 8'hE0;
  localparam logic [7:0] EXE_LH  = 8'hE1;
  localparam logic [7:0] EXE_LW  = 8'hE3;
  localparam logic [7:0] EXE_LBU = 8'hE4;
  localparam logic [7:0] EXE_LHU = 8'hE5;
  localparam logic [7:0] EXE_SB  = 8'hE8;
  localparam logic [7:0] EXE_SH  = 8'hE9;
  localparam logic [7:0] EXE_SW  = 8'hEB;

  localparam logic [2:0] EXE_RES_LS = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_LAST, S_DONE} state_t;

  // Number of bytes moved by an op; zero marks a non load/store op.
  function automatic logic [2:0] ls_width(input logic [ALUOP_BUS_W-1:0] op);
    case (op)
      EXE_LB, EXE_LBU, EXE_SB: ls_width = 3'd1;
      EXE_LH, EXE_LHU, EXE_SH: ls_width = 3'd2;
      EXE_LW, EXE_SW:          ls_width = 3'd4;
      default:                 ls_width = 3'd0;
    endcase
  endfunction

  function automatic logic is_store(input logic [ALUOP_BUS_W-1:0] op);
    case (op)
      EXE_SB, EXE_SH, EXE_SW: is_store = 1'b1;
      default:                is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [ALUOP_BUS_W-1:0] op);
    case (op)
      EXE_LB, EXE_LBU, EXE_LH, EXE_LHU, EXE_LW: is_load = 1'b1;
      default:                                  is_load = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Turns the little-endian byte buffer of a finished load into the 32-bit
// register value (sign- or zero-extended by op).
module mem_load_ext
  import mem_access_pkg::*;
#(
  parameter int ALUOP_W = ALUOP_BUS_W
) (
  input  logic [31:0]        byte_buf,
  input  logic [ALUOP_W-1:0] aluop,
  output logic [31:0]        result
);

  // Select extension by load op.
  always_comb begin
    result = 32'd0;
    case (aluop)
      EXE_LB:  result = {{24{byte_buf[7]}}, byte_buf[7:0]};
      EXE_LBU: result = {24'd0, byte_buf[7:0]};
      EXE_LH:  result = {{16{byte_buf[15]}}, byte_buf[15:0]};
      EXE_LHU: result = {16'd0, byte_buf[15:0]};
      EXE_LW:  result = byte_buf;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: serialises loads/stores one byte per cycle over the shared RAM
// port and stalls the pipeline until the access finishes.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W  = RAM_ADDR_W,
  parameter int ALUOP_W = ALUOP_BUS_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic               mem_rw_i,
  input  logic [ADDR_W-1:0]  mem_addr_i,
  input  logic [31:0]        mem_wdata_i,
  input  logic [4:0]         wd_i,
  input  logic               wreg_i,
  input  logic [31:0]        wdata_i,
  output logic               ram_req_o,
  input  logic               ram_gnt_i,
  output logic [ADDR_W-1:0]  ram_addr_o,
  output logic               ram_wr_o,
  output logic [7:0]         ram_dout_o,
  input  logic [7:0]         ram_din_i,
  output logic [4:0]         wd_o,
  output logic               wreg_o,
  output logic [31:0]        wdata_o,
  output logic               stall_req_o
);

  state_t      state_r;
  logic [2:0]  cnt_r;
  logic        pend_r;
  logic [31:0] buf_r;

  logic [2:0]  n_s;
  logic        load_s;
  logic        store_s;
  logic        ls_s;
  logic        req_s;
  logic        issue_s;
  logic        last_s;
  logic [1:0]  cap_idx_s;
  logic [31:0] ext_s;

  // Op decode and per-cycle transfer control.
  always_comb begin
    n_s       = ls_width(aluop_i);
    load_s    = is_load(aluop_i);
    store_s   = is_store(aluop_i);
    ls_s      = mem_rw_i && (n_s != 3'd0);
    req_s     = rst && (((state_r == S_IDLE) && ls_s) || (state_r == S_XFER));
    issue_s   = req_s && ram_gnt_i;
    last_s    = ((cnt_r + 3'd1) == n_s);
    cap_idx_s = cnt_r[1:0] - 2'd1;
  end

  mem_load_ext #(.ALUOP_W(ALUOP_W)) u_load_ext (
    .byte_buf (buf_r),
    .aluop    (aluop_i),
    .result   (ext_s)
  );

  // RAM port and MEM/WB outputs; held at zero while reset is asserted.
  always_comb begin
    ram_req_o   = 1'b0;
    ram_addr_o  = {ADDR_W{1'b0}};
    ram_wr_o    = 1'b0;
    ram_dout_o  = 8'd0;
    stall_req_o = 1'b0;
    wd_o        = 5'd0;
    wreg_o      = 1'b0;
    wdata_o     = 32'd0;
    if (!rst) begin
      wdata_o = 32'd0;
    end else begin
      ram_req_o   = req_s;
      ram_addr_o  = mem_addr_i + {{(ADDR_W-3){1'b0}}, cnt_r};
      ram_wr_o    = issue_s && store_s;
      ram_dout_o  = mem_wdata_i[{cnt_r[1:0], 3'b000} +: 8];
      stall_req_o = ((state_r == S_IDLE) && ls_s) || (state_r == S_XFER) || (state_r == S_LAST);
      wd_o        = wd_i;
      if (state_r == S_DONE) begin
        wreg_o  = load_s ? wreg_i : 1'b0;
        wdata_o = load_s ? ext_s : wdata_i;
      end else if (ls_s) begin
        // Bubble towards MEM/WB while the access is still running.
        wreg_o  = 1'b0;
        wdata_o = 32'd0;
      end else begin
        wreg_o  = wreg_i && !mem_rw_i;
        wdata_o = wdata_i;
      end
    end
  end

  // Transfer FSM, byte counter and load byte capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      cnt_r   <= 3'd0;
      pend_r  <= 1'b0;
      buf_r   <= 32'd0;
    end else begin
      // Read data trails its address by one cycle; pend marks a byte in flight.
      if (pend_r) begin
        buf_r[{cap_idx_s, 3'b000} +: 8] <= ram_din_i;
      end
      pend_r <= issue_s;
      case (state_r)
        S_IDLE: begin
          if (issue_s) begin
            cnt_r <= 3'd1;
            if (last_s) begin
              state_r <= load_s ? S_LAST : S_DONE;
            end else begin
              state_r <= S_XFER;
            end
          end
        end
        S_XFER: begin
          if (issue_s) begin
            cnt_r <= cnt_r + 3'd1;
            if (last_s) begin
              state_r <= load_s ? S_LAST : S_DONE;
            end
          end
        end
        S_LAST: state_r <= S_DONE;
        S_DONE: begin
          state_r <= S_IDLE;
          cnt_r   <= 3'd0;
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a byte RAM with one-cycle read latency, a
// per-transaction timeline model and literal pins on the key results.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    aluop_i = EXE_ADD;
  logic          mem_rw_i = 1'b0;
  logic [AW-1:0] mem_addr_i = '0;
  logic [31:0]   mem_wdata_i = 32'd0;
  logic [4:0]    wd_i = 5'd0;
  logic          wreg_i = 1'b0;
  logic [31:0]   wdata_i = 32'd0;
  logic          ram_req_o;
  logic          ram_gnt_i = 1'b0;
  logic [AW-1:0] ram_addr_o;
  logic          ram_wr_o;
  logic [7:0]    ram_dout_o;
  logic [7:0]    ram_din_i = 8'd0;
  logic [4:0]    wd_o;
  logic          wreg_o;
  logic [31:0]   wdata_o;
  logic          stall_req_o;

  int checks = 0;
  int failures = 0;

  logic [7:0] ram     [0:(1<<AW)-1];
  logic [7:0] ref_mem [0:(1<<AW)-1];

  logic          exp_stall [0:31];
  logic          exp_req   [0:31];
  logic          exp_wr    [0:31];
  logic [AW-1:0] exp_addr  [0:31];
  logic [7:0]    exp_dout  [0:31];
  int            exp_len = 0;
  logic          exp_load = 1'b0;
  logic [31:0]   exp_val = 32'd0;
  logic [4:0]    exp_wd = 5'd0;
  logic          exp_wreg = 1'b0;
  logic [31:0]   got_val = 32'd0;
  logic          chk_en = 1'b0;
  int            cyc = 0;

  mem_access dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop_i),
    .mem_rw_i    (mem_rw_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .ram_req_o   (ram_req_o),
    .ram_gnt_i   (ram_gnt_i),
    .ram_addr_o  (ram_addr_o),
    .ram_wr_o    (ram_wr_o),
    .ram_dout_o  (ram_dout_o),
    .ram_din_i   (ram_din_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stall_req_o (stall_req_o)
  );

  always #5 clk = ~clk;

  // Byte RAM: read data is the byte at the address issued in the previous cycle.
  always @(posedge clk) begin
    ram_din_i <= ram[ram_addr_o];
    if (ram_req_o && ram_gnt_i && ram_wr_o) ram[ram_addr_o] <= ram_dout_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the transaction timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'd0, stall_req_o}, {31'd0, exp_stall[cyc]});
      check("ram_req", {31'd0, ram_req_o}, {31'd0, exp_req[cyc]});
      check("ram_wr", {31'd0, ram_wr_o}, {31'd0, exp_wr[cyc]});
      if (exp_req[cyc]) check("ram_addr", {15'd0, ram_addr_o}, {15'd0, exp_addr[cyc]});
      if (exp_wr[cyc]) check("ram_dout", {24'd0, ram_dout_o}, {24'd0, exp_dout[cyc]});
      if (cyc == exp_len) begin
        check("done_wreg", {31'd0, wreg_o}, {31'd0, exp_wreg});
        check("done_wd", {27'd0, wd_o}, {27'd0, exp_wd});
        if (exp_load) check("done_wdata", wdata_o, exp_val);
        got_val = wdata_o;
      end
    end
  end

  // Builds the expected timeline from the grant pattern, then drives the op.
  task automatic run_op(input logic [7:0] op, input logic [AW-1:0] a, input logic [31:0] wdat,
                        input logic [4:0] wd, input logic wr_en, input logic [31:0] pat);
    int n;
    int k;
    int tlast;
    logic st;
    logic sgn;
    logic [AW-1:0] ad;
    longint v;
    n     = (op == EXE_LB || op == EXE_LBU || op == EXE_SB) ? 1 :
            (op == EXE_LH || op == EXE_LHU || op == EXE_SH) ? 2 : 4;
    st    = (op == EXE_SB || op == EXE_SH || op == EXE_SW);
    sgn   = (op == EXE_LB || op == EXE_LH);
    k     = 0;
    tlast = 0;
    for (int c = 0; c < 32; c++) begin
      exp_req[c]  = 1'b0;
      exp_wr[c]   = 1'b0;
      exp_addr[c] = '0;
      exp_dout[c] = 8'd0;
      if (k < n) begin
        ad = a + AW'(k);
        exp_req[c]  = 1'b1;
        exp_addr[c] = ad;
        exp_dout[c] = wdat[8*k +: 8];
        if (pat[c]) begin
          exp_wr[c] = st;
          if (st) ref_mem[ad] = wdat[8*k +: 8];
          k++;
          if (k == n) tlast = c;
        end
      end
    end
    exp_len = st ? tlast + 1 : tlast + 2;
    for (int c = 0; c < 32; c++) exp_stall[c] = (c < exp_len);
    v = 0;
    for (int j = 0; j < n; j++) begin
      ad = a + AW'(j);
      v  = v + (longint'(ref_mem[ad]) << (8 * j));
    end
    if (sgn && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    exp_val  = v[31:0];
    exp_load = !st;
    exp_wd   = wd;
    exp_wreg = st ? 1'b0 : wr_en;

    @(posedge clk); #1;
    aluop_i = op; mem_rw_i = 1'b1; mem_addr_i = a; mem_wdata_i = wdat;
    wd_i = wd; wreg_i = wr_en; wdata_i = 32'hCAFE0000;
    for (int c = 0; c <= exp_len; c++) begin
      cyc = c;
      ram_gnt_i = pat[c];
      chk_en = 1'b1;
      @(posedge clk); #1;
    end
    chk_en = 1'b0; mem_rw_i = 1'b0; aluop_i = EXE_ADD; ram_gnt_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] <= 8'd0;
      ref_mem[i] = 8'd0;
    end
    ram[17'h100] <= 8'h78; ram[17'h101] <= 8'h56; ram[17'h102] <= 8'h34; ram[17'h103] <= 8'h12;
    ram[17'h200] <= 8'h80;
    ref_mem[17'h100] = 8'h78; ref_mem[17'h101] = 8'h56; ref_mem[17'h102] = 8'h34; ref_mem[17'h103] = 8'h12;
    ref_mem[17'h200] = 8'h80;

    // Reset with a load presented: everything must stay quiet.
    rst = 1'b0; aluop_i = EXE_LW; mem_rw_i = 1'b1; ram_gnt_i = 1'b1; wreg_i = 1'b1; wdata_i = 32'h5; wd_i = 5'd7;
    @(negedge clk);
    check("rst_stall", {31'd0, stall_req_o}, 32'd0);
    check("rst_req", {31'd0, ram_req_o}, 32'd0);
    check("rst_wr", {31'd0, ram_wr_o}, 32'd0);
    check("rst_wreg", {31'd0, wreg_o}, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    mem_rw_i = 1'b0; aluop_i = EXE_ADD; ram_gnt_i = 1'b0;
    @(posedge clk); #1; rst = 1'b1;

    // Non-memory pass-through.
    wdata_i = 32'h5; wd_i = 5'd3; wreg_i = 1'b1; mem_rw_i = 1'b0; aluop_i = EXE_ADD;
    #1;
    check("add_wdata", wdata_o, 32'h5);
    check("add_wd", {27'd0, wd_o}, 32'd3);
    check("add_stall", {31'd0, stall_req_o}, 32'd0);
    check("add_req", {31'd0, ram_req_o}, 32'd0);
    mem_rw_i = 1'b1;
    #1;
    check("nonls_wreg", {31'd0, wreg_o}, 32'd0);
    check("nonls_stall", {31'd0, stall_req_o}, 32'd0);
    mem_rw_i = 1'b0;

    run_op(EXE_LW, 17'h00100, 32'h0, 5'd5, 1'b1, 32'hFFFFFFFF);
    check("lw_pin", got_val, 32'h12345678);
    check("lw_len", exp_len, 5);
    run_op(EXE_LB, 17'h00200, 32'h0, 5'd6, 1'b1, 32'hFFFFFFFF);
    check("lb_pin", got_val, 32'hFFFFFF80);
    run_op(EXE_LBU, 17'h00200, 32'h0, 5'd6, 1'b1, 32'hFFFFFFFF);
    check("lbu_pin", got_val, 32'h00000080);
    run_op(EXE_SH, 17'h1FFFF, 32'hDEADBEEF, 5'd8, 1'b1, 32'hFFFFFFFF);
    check("sh_byte0", {24'd0, ram[17'h1FFFF]}, 32'hEF);
    check("sh_byte1_wrap", {24'd0, ram[17'h00000]}, 32'hBE);
    run_op(EXE_LW, 17'h00100, 32'h0, 5'd9, 1'b1, 32'h00000039);
    check("lw_gap_pin", got_val, 32'h12345678);
    check("lw_gap_len", exp_len, 7);
    run_op(EXE_LH, 17'h1FFFF, 32'h0, 5'd10, 1'b1, 32'hFFFFFFFF);
    check("lh_wrap_pin", got_val, 32'hFFFFBEEF);

    // Store aborted by reset after two bytes.
    @(posedge clk); #1;
    aluop_i = EXE_SW; mem_rw_i = 1'b1; mem_addr_i = 17'h00300; mem_wdata_i = 32'hA1B2C3D4; ram_gnt_i = 1'b1;
    @(posedge clk); #1;
    check("sw_b1_wr", {31'd0, ram_wr_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_wr", {31'd0, ram_wr_o}, 32'd0);
    check("abort_stall", {31'd0, stall_req_o}, 32'd0);
    check("abort_req", {31'd0, ram_req_o}, 32'd0);
    @(posedge clk); #1;
    mem_rw_i = 1'b0; aluop_i = EXE_ADD; ram_gnt_i = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    check("abort_b0", {24'd0, ram[17'h300]}, 32'hD4);
    check("abort_b1", {24'd0, ram[17'h301]}, 32'hC3);
    check("abort_b2", {24'd0, ram[17'h302]}, 32'h00);
    check("abort_b3", {24'd0, ram[17'h303]}, 32'h00);
    ref_mem[17'h300] = 8'hD4; ref_mem[17'h301] = 8'hC3;
    run_op(EXE_LHU, 17'h00301, 32'h0, 5'd11, 1'b1, 32'hFFFFFFFF);
    check("lhu_after_abort", got_val, 32'h000000C3);
    run_op(EXE_SB, 17'h00400, 32'h0000005A, 5'd12, 1'b1, 32'h00000006);
    check("sb_byte", {24'd0, ram[17'h400]}, 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the 5-stage RV32I pipeline.
- Sits between the EX/MEM pipeline register (fed from EX: address, store data, aluop, mem_rw, wd/wreg/wdata) and the MEM/WB register.
- Performs LB/LH/LW/LBU/LHU/SB/SH/SW over the byte-wide, single-port unified RAM. Transfers are serialised one byte per cycle through a req/gnt arbiter shared with IF.
- Stalls the pipeline until the access completes. Non-memory ops pass straight through with no added latency.

Parameters:
ADDR_W, 17, RAM byte-address width (RamAddrBus)
ALUOP_W, 8, aluop width (AluOpBus)

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  reset, asynchronous, active-low (one clock domain; polarity and synchronicity fixed)
aluop_i  in  ALUOP_W  op code from EX/MEM register
mem_rw_i  in  1  1 = memory op present
mem_addr_i  in  ADDR_W  effective byte address
mem_wdata_i  in  32  store data (low bytes used)
wd_i  in  5  destination register
wreg_i  in  1  register write enable
wdata_i  in  32  ALU/link result for non-memory ops
ram_req_o  out  1  request RAM port
ram_gnt_i  in  1  arbiter grant, valid same cycle as request
ram_addr_o  out  ADDR_W  byte address
ram_wr_o  out  1  1 = write byte this cycle
ram_dout_o  out  8  write byte
ram_din_i  in  8  read byte, valid the cycle after the address is issued
wd_o  out  5  to MEM/WB
wreg_o  out  1  to MEM/WB
wdata_o  out  32  to MEM/WB
stall_req_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, pend=0, data buffer=0. All outputs 0: no RAM write, no stall.
- Width n: B ops = 1, H ops = 2, W = 3-bit code for 4 bytes (n=4). Little-endian: byte k goes to addr+k, wrapping modulo 2^ADDR_W. Misaligned addresses are legal.
- Non-mem (mem_rw_i=0), or mem_rw_i=1 with a non-LS aluop:
  - wd_o/wreg_o/wdata_o = inputs, combinationally in the same cycle.
  - stall_req_o=0 and ram_req_o=0.
  - A non-LS aluop forces wreg_o=0.
- States: IDLE, XFER, LAST, DONE.
- IDLE:
  - On an LS op, stall_req_o=1 and ram_req_o=1 with ram_addr_o=addr.
  - If gnt: byte 0 is issued, cnt<=1, pend<=1, then go to XFER if n>1. If n=1, go to LAST for a load and DONE for a store.
  - Without gnt: stay in IDLE, nothing issued.
- XFER: request byte cnt.
  - On gnt: issue it and cnt++. After byte n-1 is issued, go to LAST (load) or DONE (store).
  - Without gnt: hold cnt.
- Load capture: whenever pend=1, ram_din_i goes into buffer byte (cnt-1). pend<=gnt of the current cycle, so gaps in the grant do not corrupt byte order.
- LAST: capture the final byte, then go to DONE. No request in this state.
- DONE:
  - stall_req_o=0.
  - wdata_o = assembled load value, sign-extended (LB/LH) or zero-extended (LBU/LHU/LW). wreg_o=wreg_i, wd_o=wd_i.
  - Stores force wreg_o=0.
  - Always return to IDLE. The upstream register advances on this same edge, so the held op is never restarted.
- Stores: ram_wr_o=1 only in granted cycles. ram_dout_o = mem_wdata_i[8k+7:8k].
- Latency with continuous gnt:
  - Load of n bytes: stall high n+1 cycles, result in cycle n+1.
  - Store of n bytes: stall high n cycles, DONE in cycle n.
- stall_req_o = (LS op in IDLE) or state in {XFER, LAST}.
- Inputs must stay stable while stall_req_o=1. This is guaranteed by the stall.
- Reset mid-transfer: abort immediately. Any partial store bytes already written stay written; no further writes.

Decomposition:
- define.v carries:
  - EXE_L*/EXE_S* op codes, EXE_RES_LS.
  - RamAddrBus and the FSM state encoding (S_IDLE/S_XFER/S_LAST/S_DONE).
  - A width-decode macro returning n from aluop.
- One combinational sub-module, mem_load_ext: takes the 32-bit byte buffer plus aluop and returns the extended 32-bit result. It is reused by any future cache fill path.

Test Plan:
- LW addr=0x00100, RAM bytes 78,56,34,12, gnt=1 -> 4 reads at 0x100..0x103; stall high cycles 0-4; cycle 5 wdata_o=0x12345678, wreg_o=1.
- LB at 0x00200=0x80 and LBU at same address -> wdata_o=0xFFFFFF80 and 0x00000080; stall 2 cycles each.
- SH addr=0x1FFFF, data=0xDEADBEEF -> writes EF@0x1FFFF, BE@0x00000 (wrap); ram_wr_o high 2 cycles; wreg_o=0 in DONE.
- LW with gnt pattern 1,0,0,1,1,1 -> addresses issued only when granted; result is still the correct little-endian word; stall spans 7 cycles.
- ADD result 0x5 (mem_rw_i=0) -> wdata_o=0x5 same cycle, stall_req_o=0, ram_req_o=0.
- SW in progress, rst low after byte 1 -> ram_wr_o drops immediately; state IDLE; only bytes 0-1 are modified in RAM.
